// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU, with a one-entry response register.
// Optional macro ALU_ARBITER_OPCHECK_EN: flags control codes 1010-1111 as illegal (rsp_err=1, result and flags zeroed).
module alu_arbiter #(
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_a,
    input  logic [31:0]     req0_b,
    input  logic [3:0]      req0_op,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_a,
    input  logic [31:0]     req1_b,
    input  logic [3:0]      req1_op,
    input  logic [TAGW-1:0] req1_tag,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [31:0]     alu_result,
    input  logic [3:0]      alu_flags,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic [3:0]      rsp_flags,
    output logic [TAGW-1:0] rsp_tag,
    output logic            rsp_src,
    output logic            rsp_err,
    output logic [15:0]     op_count
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_next;
    logic            last_grant;
    logic            gnt0, gnt1;
    logic            can_accept, accept;
    logic [TAGW-1:0] gnt_tag;
    logic [31:0]     cap_result;
    logic [3:0]      cap_flags;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_grant);
        gnt1       = req1_valid & (~req0_valid | ~last_grant);
        can_accept = (state == IDLE) | rsp_ready;
        accept     = (gnt0 | gnt1) & can_accept;
        req0_ready = gnt0 & can_accept;
        req1_ready = gnt1 & can_accept;
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        gnt_tag  = '0;
        if (gnt1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_op;
            gnt_tag  = req1_tag;
        end else if (gnt0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_op;
            gnt_tag  = req0_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new accept always lands in HOLD, even if the old response drains in the same cycle.
    always_comb begin
        state_next = state;
        rsp_valid  = (state == HOLD);
        if (accept) begin
            state_next = HOLD;
        end else if ((state == HOLD) && rsp_ready) begin
            state_next = IDLE;
        end
    end

`ifdef ALU_ARBITER_OPCHECK_EN
    logic illegal_op;
    logic err_q;

    assign illegal_op = (alu_ctrl > 4'd9);
    assign cap_result = illegal_op ? 32'd0 : alu_result;
    assign cap_flags  = illegal_op ? 4'd0 : alu_flags;
    assign rsp_err    = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= illegal_op;
        end
    end
`else
    assign cap_result = alu_result;
    assign cap_flags  = alu_flags;
    assign rsp_err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_tag    <= '0;
            rsp_src    <= 1'b0;
            op_count   <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_result <= cap_result;
            rsp_flags  <= cap_flags;
            rsp_tag    <= gnt_tag;
            rsp_src    <= gnt1;
            op_count   <= op_count + 16'd1;
            last_grant <= gnt1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a behavioural ALU model answers the arbiter's alu_* outputs.
// Build with ALU_ARBITER_OPCHECK_EN defined to exercise the illegal-op check.
module tb_alu_arbiter;

    localparam int TAGW = 4;

    typedef struct packed {
        logic            valid;
        logic [3:0]      op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAGW-1:0] tag;
    } req_t;

    typedef struct packed {
        logic            src;
        logic [3:0]      op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [TAGW-1:0] tag;
        logic [31:0]     exp_result;
        logic [3:0]      exp_flags;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0]     req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_op, req1_op;
    logic [TAGW-1:0] req0_tag, req1_tag;
    logic [31:0]     alu_a, alu_b, alu_result;
    logic [3:0]      alu_ctrl, alu_flags;
    logic            rsp_valid, rsp_ready, rsp_src, rsp_err;
    logic [31:0]     rsp_result;
    logic [3:0]      rsp_flags;
    logic [TAGW-1:0] rsp_tag;
    logic [15:0]     op_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.TAGW(TAGW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // ALU model: flags are {Carry, OverFlow, Zero, Negative}; SUB carry means borrow; undefined codes give DEADBEEF.
    always_comb begin
        logic [32:0] wide;
        logic        c, v;
        wide = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                c    = wide[32];
                v    = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'd1: begin
                wide = {1'b0, alu_a - alu_b};
                c    = (alu_a < alu_b);
                v    = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'd2: wide = {1'b0, alu_a & alu_b};
            4'd3: wide = {1'b0, alu_a | alu_b};
            4'd4: wide = {1'b0, alu_a ^ alu_b};
            4'd5: wide = {1'b0, ~(alu_a | alu_b)};
            4'd6: wide = {32'd0, ($signed(alu_a) < $signed(alu_b))};
            4'd7: wide = {1'b0, alu_a << alu_b[4:0]};
            4'd8: wide = {1'b0, alu_a >> alu_b[4:0]};
            4'd9: wide = {1'b0, $signed(alu_a) >>> alu_b[4:0]};
            default: wide = {1'b0, 32'hDEADBEEF};
        endcase
        alu_result = wide[31:0];
        alu_flags  = {c, v, (wide[31:0] == 32'd0), wide[31]};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input req_t r0, input req_t r1, input logic rr);
        @(negedge clk);
        req0_valid = r0.valid; req0_op = r0.op; req0_a = r0.a; req0_b = r0.b; req0_tag = r0.tag;
        req1_valid = r1.valid; req1_op = r1.op; req1_a = r1.a; req1_b = r1.b; req1_tag = r1.tag;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];
    req_t idle_req;
    logic exp_src;

    initial begin
        idle_req = '0;
        vecs[0] = '{1'b0, 4'd0, 32'd7,         32'd5,         4'd3, 32'd12,        4'b0000};
        vecs[1] = '{1'b1, 4'd1, 32'h80000000,  32'd1,         4'd5, 32'h7FFFFFFF,  4'b0100};
        vecs[2] = '{1'b0, 4'd9, 32'h80000000,  32'd4,         4'd9, 32'hF8000000,  4'b0001};
        vecs[3] = '{1'b1, 4'd2, 32'hF0F0F0F0,  32'hFF00FF00,  4'hA, 32'hF000F000,  4'b0001};
        vecs[4] = '{1'b0, 4'd0, 32'hFFFFFFFF,  32'd1,         4'd1, 32'd0,         4'b1010};
        vecs[5] = '{1'b1, 4'd7, 32'd1,         32'd31,        4'hF, 32'h80000000,  4'b0001};
        vecs[6] = '{1'b0, 4'd4, 32'hA5A5A5A5,  32'hA5A5A5A5,  4'd6, 32'd0,         4'b0010};

        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
        req1_op = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_result", rsp_result, 0);
        checkOutput("reset rsp_flags", rsp_flags, 0);
        checkOutput("reset rsp_tag", rsp_tag, 0);
        checkOutput("reset rsp_src", rsp_src, 0);
        checkOutput("reset rsp_err", rsp_err, 0);
        checkOutput("reset op_count", op_count, 0);
        rst = 1'b0;

        // Round robin: both requesters valid for four cycles straight after reset.
        for (int k = 0; k < 4; k++) begin
            exp_src = k[0];
            applyStimulus('{1'b1, 4'd0, 32'd10, 32'd1, 4'd0}, '{1'b1, 4'd0, 32'd20, 32'd2, 4'd1}, 1'b1);
            checkOutput("rr req0_ready", req0_ready, !exp_src);
            checkOutput("rr req1_ready", req1_ready, exp_src);
            checkOutput("rr alu_a", alu_a, exp_src ? 32'd20 : 32'd10);
            after_edge();
            checkOutput("rr rsp_valid", rsp_valid, 1);
            checkOutput("rr rsp_src", rsp_src, exp_src);
            checkOutput("rr rsp_result", rsp_result, exp_src ? 32'd22 : 32'd11);
        end
        checkOutput("rr op_count", op_count, 4);
        applyStimulus(idle_req, idle_req, 1'b1);
        checkOutput("idle alu_a", alu_a, 0);
        checkOutput("idle alu_ctrl", alu_ctrl, 0);
        after_edge();
        checkOutput("drain rsp_valid", rsp_valid, 0);

        // Single-request vectors, each from IDLE, followed by a drain cycle.
        for (int i = 0; i < 7; i++) begin
            req_t r;
            r = '{1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag};
            if (vecs[i].src) applyStimulus(idle_req, r, 1'b1);
            else             applyStimulus(r, idle_req, 1'b1);
            checkOutput($sformatf("v%0d req0_ready", i), req0_ready, !vecs[i].src);
            checkOutput($sformatf("v%0d req1_ready", i), req1_ready, vecs[i].src);
            checkOutput($sformatf("v%0d rsp_valid early", i), rsp_valid, 0);
            after_edge();
            checkOutput($sformatf("v%0d rsp_valid", i), rsp_valid, 1);
            checkOutput($sformatf("v%0d rsp_result", i), rsp_result, vecs[i].exp_result);
            checkOutput($sformatf("v%0d rsp_flags", i), rsp_flags, vecs[i].exp_flags);
            checkOutput($sformatf("v%0d rsp_tag", i), rsp_tag, vecs[i].tag);
            checkOutput($sformatf("v%0d rsp_src", i), rsp_src, vecs[i].src);
            checkOutput($sformatf("v%0d rsp_err", i), rsp_err, 0);
            applyStimulus(idle_req, idle_req, 1'b1);
            after_edge();
        end
        checkOutput("table op_count", op_count, 11);

        // Backpressure: SUB 5-5 held for three stalled cycles while both requesters wait.
        applyStimulus(idle_req, '{1'b1, 4'd1, 32'd5, 32'd5, 4'd2}, 1'b1);
        after_edge();
        for (int k = 0; k < 3; k++) begin
            applyStimulus('{1'b1, 4'd0, 32'd1, 32'd1, 4'd8}, '{1'b1, 4'd0, 32'd3, 32'd3, 4'd9}, 1'b0);
            checkOutput("hold req0_ready", req0_ready, 0);
            checkOutput("hold req1_ready", req1_ready, 0);
            after_edge();
            checkOutput("hold rsp_valid", rsp_valid, 1);
            checkOutput("hold rsp_result", rsp_result, 0);
            checkOutput("hold rsp_flags", rsp_flags, 4'b0010);
            checkOutput("hold rsp_tag", rsp_tag, 2);
            checkOutput("hold rsp_src", rsp_src, 1);
        end
        checkOutput("hold op_count", op_count, 12);
        applyStimulus(idle_req, idle_req, 1'b1);
        after_edge();
        checkOutput("release rsp_valid", rsp_valid, 0);

        // Undefined control code 1100.
        applyStimulus('{1'b1, 4'b1100, 32'd3, 32'd4, 4'd7}, idle_req, 1'b1);
        after_edge();
        checkOutput("illegal rsp_valid", rsp_valid, 1);
        checkOutput("illegal rsp_tag", rsp_tag, 7);
`ifdef ALU_ARBITER_OPCHECK_EN
        checkOutput("illegal rsp_err", rsp_err, 1);
        checkOutput("illegal rsp_result", rsp_result, 0);
        checkOutput("illegal rsp_flags", rsp_flags, 0);
`else
        checkOutput("illegal rsp_err", rsp_err, 0);
        checkOutput("illegal rsp_result", rsp_result, 32'hDEADBEEF);
        checkOutput("illegal rsp_flags", rsp_flags, 4'b0001);
`endif
        checkOutput("illegal op_count", op_count, 13);
        applyStimulus(idle_req, idle_req, 1'b1);
        after_edge();

        // Reset pulse while a response is held; last accept was requester 0, so requester 1 would win without reset.
        applyStimulus('{1'b1, 4'd0, 32'd1, 32'd2, 4'd4}, idle_req, 1'b1);
        after_edge();
        applyStimulus(idle_req, idle_req, 1'b0);
        checkOutput("pre-reset rsp_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid-reset rsp_valid", rsp_valid, 0);
        checkOutput("mid-reset op_count", op_count, 0);
        checkOutput("mid-reset rsp_result", rsp_result, 0);
        checkOutput("mid-reset rsp_tag", rsp_tag, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(idle_req, idle_req, 1'b1);
        after_edge();
        checkOutput("post-reset rsp_valid", rsp_valid, 0);
        applyStimulus('{1'b1, 4'd0, 32'd2, 32'd2, 4'd1}, '{1'b1, 4'd0, 32'd5, 32'd5, 4'd2}, 1'b1);
        checkOutput("post-reset req0_ready", req0_ready, 1);
        checkOutput("post-reset req1_ready", req1_ready, 0);
        after_edge();
        checkOutput("post-reset rsp_src", rsp_src, 0);
        checkOutput("post-reset rsp_result", rsp_result, 4);
        checkOutput("post-reset op_count", op_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: TAGW, 4, width of the per-request tag echoed on the response.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  requester n operation accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b / req1_a, req1_b  input  32  operands.
REQ-007 SHALL have ports: req0_op / req1_op  input  4  ALU control code, 0000 ADD through 1001 SRA.
REQ-008 SHALL have ports: req0_tag / req1_tag  input  TAGW  requester tag.
REQ-009 SHALL have ports: alu_a, alu_b  output  32, and alu_ctrl  output  4; these drive the shared combinational ALU.
REQ-010 SHALL have ports: alu_result  input  32, and alu_flags  input  4; alu_flags is {Carry, OverFlow, Zero, Negative} from the ALU.
REQ-011 SHALL have ports: rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-012 SHALL have ports: rsp_result  output  32; rsp_flags  output  4; rsp_tag  output  TAGW; rsp_src  output  1 (requester id); rsp_err  output  1 (illegal op).
REQ-013 SHALL have port: op_count  output  16  number of accepted operations, wraps from FFFF to 0000.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (rsp_valid=0) and HOLD (rsp_valid=1).
REQ-015 SHALL define can_accept = (state==IDLE) | rsp_ready; at most one request is accepted per cycle.
REQ-016 SHALL grant round-robin: the sole valid requester wins; if both are valid, the requester other than last_grant wins.
REQ-017 SHALL assert reqN_ready = granted(N) & can_accept; an accept is a cycle with reqN_valid & reqN_ready.
REQ-018 SHALL update last_grant only on an accept.
REQ-019 SHALL drive alu_a, alu_b and alu_ctrl combinationally from the granted requester, and drive them to zero when no request is valid.
REQ-020 SHALL, on an accept, register alu_result, alu_flags, tag and requester id into the response registers and enter HOLD; rsp_valid rises the next cycle, giving 1-cycle latency.
REQ-021 SHALL, in HOLD with rsp_ready=1 and an accept in the same cycle, replace the response and stay in HOLD, giving back-to-back throughput of 1 operation per cycle.
REQ-022 SHALL, in HOLD with rsp_ready=1 and no accept, return to IDLE.
REQ-023 SHALL keep all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0, and deassert both reqN_ready outputs during that time.
REQ-024 SHALL increment op_count by 1 on each accept.

Reset
REQ-025 SHALL, while rst=1, force: state=IDLE, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_tag=0, rsp_src=0, rsp_err=0, op_count=0, last_grant=1 (so requester 0 wins the first contention).
REQ-026 SHALL discard any held response when reset asserts mid-operation; no response is emitted for it after reset releases.

Configuration
REQ-027 SHALL, when macro ALU_ARBITER_OPCHECK_EN is defined, flag ops 1010-1111 on accept with rsp_err=1, rsp_result=0 and rsp_flags=0000 (Zero flag not set).
REQ-028 SHALL, when ALU_ARBITER_OPCHECK_EN is undefined, tie rsp_err to 0 and pass alu_result and alu_flags through unchanged for every op.

Verification
REQ-029 SHALL cover: req0 ADD a=7 b=5 tag=3, rsp_ready=1 -> rsp_valid next cycle with result 12, flags 0000, tag 3, src 0.
REQ-030 SHALL cover: both requesters valid for 4 cycles after reset, rsp_ready=1 -> grants in order 0,1,0,1, and op_count=4.
REQ-031 SHALL cover: req1 SUB a=5 b=5 with rsp_ready=0 for 3 cycles -> result 0 with Z=1 held stable, req ready outputs 0, then released when rsp_ready=1.
REQ-032 SHALL cover: SUB a=80000000 b=1 -> result 7FFFFFFF with V=1; SRA a=80000000 b=4 -> result F8000000 with N=1.
REQ-033 SHALL cover: op=1100 with ALU_ARBITER_OPCHECK_EN defined -> rsp_err=1 and result 0; with it undefined -> rsp_err=0.
REQ-034 SHALL cover: rst pulse while in HOLD -> rsp_valid=0 immediately, op_count=0, and the next contention is won by requester 0.
